// File: rtl/combo_lock_n_if.sv
// rtl/combo_lock_n_if.sv - button/switch inputs and led/ssd outputs of the combination lock
interface combo_lock_n_if #(
  parameter int N_DIGITS = 4
);
  logic                  clr;
  logic                  ent;
  logic                  change;
  logic [3:0]            sw;
  logic [5:0]            led;
  logic [5*N_DIGITS-1:0] ssd;

  modport master (output clr, ent, change, sw, input led, ssd);
  modport slave  (input clr, ent, change, sw, output led, ssd);
endinterface

// File: rtl/combo_lock_n.sv
// rtl/combo_lock_n.sv - parametrised combination lock with fail counter, lockout and blinking display
module combo_lock_n #(
  parameter int                    N_DIGITS    = 4,
  parameter logic [4*N_DIGITS-1:0] DEFAULT_PW  = '0,
  parameter int                    BLINK_HALF  = 50_000_000,
  parameter int                    MAX_FAILS   = 3,
  parameter int                    LOCKOUT_CYC = 500_000_000
) (
  input  logic          clk,
  input  logic          rst,
  combo_lock_n_if.slave bus
);

  localparam int PW_W  = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int LW    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [4:0] CH_ZERO  = 5'h00;
  localparam logic [4:0] CH_DASH  = 5'h10;
  localparam logic [4:0] CH_BLANK = 5'h11;
  localparam logic [4:0] CH_L     = 5'h12;
  localparam logic [4:0] CH_P     = 5'h13;

  typedef enum logic [2:0] {
    S_LOCKED, S_ENTER, S_CHECK, S_UNLOCKED, S_NEWPW, S_LOCKOUT
  } state_t;

  state_t                state;
  logic [PW_W-1:0]       password;
  logic [PW_W-1:0]       in_pw;
  logic [PW_W-1:0]       staged;
  logic [IDX_W-1:0]      idx;
  logic [2:0]            fails;
  logic [LW-1:0]         lock_cnt;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_hidden;
  logic                  clr_q, ent_q, chg_q;
  logic                  ev_clr, ev_ent, ev_chg;
  logic                  idx_last;
  logic                  fail_limit;
  logic [5*N_DIGITS-1:0] ssd_next;
  logic [5:0]            led_next;
  logic [5*N_DIGITS-1:0] ssd_q;
  logic [5:0]            led_q;

  assign bus.led = led_q;
  assign bus.ssd = ssd_q;

  // Digit 0 sits in the most significant nibble.
  function automatic logic [PW_W-1:0] put_digit(input logic [PW_W-1:0] v,
                                                input logic [IDX_W-1:0] i,
                                                input logic [3:0] d);
    logic [PW_W-1:0] r;
    r = v;
    r[4*(N_DIGITS-1-int'(i)) +: 4] = d;
    return r;
  endfunction

  // Rising-edge events with one-hot priority clr > ent > change.
  always_comb begin
    ev_clr     = bus.clr & ~clr_q;
    ev_ent     = bus.ent & ~ent_q & ~ev_clr;
    ev_chg     = bus.change & ~chg_q & ~ev_clr & ~ev_ent;
    idx_last   = (idx == IDX_W'(N_DIGITS - 1));
    fail_limit = (({1'b0, fails} + 4'd1) == 4'(MAX_FAILS));
  end

  // Button history; reset to 1 so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q <= 1'b1;
      ent_q <= 1'b1;
      chg_q <= 1'b1;
    end else begin
      clr_q <= bus.clr;
      ent_q <= bus.ent;
      chg_q <= bus.change;
    end
  end

  // Free-running blink prescaler; phase flips each BLINK_HALF cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt    <= '0;
      blink_hidden <= ~blink_hidden;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Lock state machine: entry, check, password change and timed lockout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOCKED;
      password <= DEFAULT_PW;
      in_pw    <= '0;
      staged   <= '0;
      idx      <= '0;
      fails    <= '0;
      lock_cnt <= '0;
    end else begin
      case (state)
        S_LOCKED: begin
          if (ev_ent) begin
            state <= S_ENTER;
            idx   <= '0;
          end
        end
        S_ENTER: begin
          if (ev_clr) begin
            idx <= '0;
          end else if (ev_ent) begin
            in_pw <= put_digit(in_pw, idx, bus.sw);
            if (idx_last) begin
              idx   <= '0;
              state <= S_CHECK;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_CHECK: begin
          if (in_pw == password) begin
            state <= S_UNLOCKED;
            fails <= '0;
          end else if (fail_limit) begin
            state    <= S_LOCKOUT;
            fails    <= 3'(MAX_FAILS);
            lock_cnt <= LW'(LOCKOUT_CYC - 1);
          end else begin
            state <= S_LOCKED;
            fails <= fails + 3'd1;
          end
        end
        S_UNLOCKED: begin
          if (ev_ent) begin
            state <= S_LOCKED;
          end else if (ev_chg) begin
            state  <= S_NEWPW;
            idx    <= '0;
            staged <= '0;
          end
        end
        S_NEWPW: begin
          if (ev_clr) begin
            idx    <= '0;
            staged <= '0;
          end else if (ev_ent) begin
            if (idx_last) begin
              password <= put_digit(staged, idx, bus.sw);
              staged   <= '0;
              idx      <= '0;
              state    <= S_LOCKED;
            end else begin
              staged <= put_digit(staged, idx, bus.sw);
              idx    <= idx + IDX_W'(1);
            end
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt == '0) begin
            state <= S_LOCKED;
            fails <= '0;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end
        default: state <= S_LOCKED;
      endcase
    end
  end

  // Next display characters and leds from the current state, sw and blink phase.
  always_comb begin
    ssd_next = {N_DIGITS{CH_BLANK}};
    led_next = {fails, 3'b000};
    case (state)
      S_LOCKED: begin
        ssd_next[5*N_DIGITS-1 -: 5] = CH_L;
        led_next[0] = 1'b1;
      end
      S_ENTER, S_NEWPW: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (i < int'(idx)) begin
            ssd_next[5*(N_DIGITS-1-i) +: 5] = CH_DASH;
          end else if (i == int'(idx)) begin
            ssd_next[5*(N_DIGITS-1-i) +: 5] = blink_hidden ? CH_BLANK : {1'b0, bus.sw};
          end
        end
        if (state == S_ENTER) led_next[0] = 1'b1;
        else                  led_next[1] = 1'b1;
      end
      S_CHECK: begin
        ssd_next    = {N_DIGITS{CH_DASH}};
        led_next[0] = 1'b1;
      end
      S_UNLOCKED: begin
        ssd_next[5*N_DIGITS-1 -: 5] = CH_ZERO;
        ssd_next[5*N_DIGITS-6 -: 5] = CH_P;
        led_next[1] = 1'b1;
      end
      S_LOCKOUT: begin
        ssd_next    = blink_hidden ? {N_DIGITS{CH_BLANK}} : {N_DIGITS{CH_DASH}};
        led_next[2] = 1'b1;
      end
      default: led_next[0] = 1'b1;
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 6'b000001;
      ssd_q <= {CH_L, {(N_DIGITS-1){CH_BLANK}}};
    end else begin
      led_q <= led_next;
      ssd_q <= ssd_next;
    end
  end

endmodule

// File: tb/tb_combo_lock_n.sv
// tb/tb_combo_lock_n.sv - vector table plus randomized model comparison for combo_lock_n
module tb_combo_lock_n;
  localparam int N    = 4;
  localparam int BH   = 4;
  localparam int MAXF = 3;
  localparam int LCYC = 20;

  localparam logic [4:0] DSH = 5'h10;
  localparam logic [4:0] BLK = 5'h11;
  localparam logic [4:0] CL  = 5'h12;
  localparam logic [4:0] CP  = 5'h13;
  localparam logic [5:0] LED_LOCK = 6'b000001;
  localparam logic [5:0] LED_UNL  = 6'b000010;

  logic clk = 1'b0;
  logic rst;

  combo_lock_n_if #(.N_DIGITS(N)) bus_if ();

  combo_lock_n #(
    .N_DIGITS(N), .DEFAULT_PW(16'h0000), .BLINK_HALF(BH),
    .MAX_FAILS(MAXF), .LOCKOUT_CYC(LCYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       r, c, e, h;
    logic [3:0] s;
    bit         cl;
    logic [5:0] led;
    bit         cs;
    logic [19:0] ssd;
  } vec_t;

  vec_t tbl[$];

  // Reference model: mode name, password digits, queue of digits typed so far.
  string       m_mode;
  int          m_pw[N];
  int          m_entry[$];
  int          m_fails, m_left, m_t;
  bit          p_clr, p_ent, p_chg;
  logic [5:0]  m_led;
  logic [19:0] m_ssd;

  function automatic logic [19:0] render(input logic [3:0] s);
    logic [4:0]  ch[N];
    logic [19:0] r;
    bit          hid;
    hid = ((m_t / BH) % 2) == 1;
    foreach (ch[i]) ch[i] = BLK;
    if (m_mode == "LOCKED") ch[0] = CL;
    else if (m_mode == "ENTER" || m_mode == "NEWPW") begin
      for (int i = 0; i < N; i++) begin
        if (i < m_entry.size()) ch[i] = DSH;
        else if (i == m_entry.size()) ch[i] = hid ? BLK : {1'b0, s};
      end
    end else if (m_mode == "CHECK") begin
      foreach (ch[i]) ch[i] = DSH;
    end else if (m_mode == "UNLOCKED") begin
      ch[0] = 5'h00;
      ch[1] = CP;
    end else begin
      foreach (ch[i]) ch[i] = hid ? BLK : DSH;
    end
    r = '0;
    for (int i = 0; i < N; i++) r = {r[14:0], ch[i]};
    return r;
  endfunction

  task automatic model_step(input logic r, c, e, h, input logic [3:0] s);
    bit ec, ee, eh, match;
    if (r) begin
      m_mode = "LOCKED";
      foreach (m_pw[i]) m_pw[i] = 0;
      m_entry.delete();
      m_fails = 0; m_left = 0; m_t = 0;
      p_clr = 1; p_ent = 1; p_chg = 1;
      m_led = 6'b000001;
      m_ssd = {CL, BLK, BLK, BLK};
    end else begin
      m_led = {3'(m_fails), m_mode == "LOCKOUT", (m_mode == "UNLOCKED" || m_mode == "NEWPW"),
               (m_mode == "LOCKED" || m_mode == "ENTER" || m_mode == "CHECK")};
      m_ssd = render(s);
      ec = c && !p_clr;
      ee = e && !p_ent && !ec;
      eh = h && !p_chg && !ec && !ee;
      p_clr = c; p_ent = e; p_chg = h;
      m_t++;
      if (m_mode == "LOCKED") begin
        if (ee) begin m_mode = "ENTER"; m_entry.delete(); end
      end else if (m_mode == "ENTER") begin
        if (ec) m_entry.delete();
        else if (ee) begin
          m_entry.push_back(int'(s));
          if (m_entry.size() == N) m_mode = "CHECK";
        end
      end else if (m_mode == "CHECK") begin
        match = 1;
        for (int i = 0; i < N; i++) if (m_entry[i] != m_pw[i]) match = 0;
        m_entry.delete();
        if (match) begin m_mode = "UNLOCKED"; m_fails = 0; end
        else if (m_fails + 1 == MAXF) begin m_mode = "LOCKOUT"; m_fails = MAXF; m_left = LCYC; end
        else begin m_fails++; m_mode = "LOCKED"; end
      end else if (m_mode == "UNLOCKED") begin
        if (ee) m_mode = "LOCKED";
        else if (eh) begin m_mode = "NEWPW"; m_entry.delete(); end
      end else if (m_mode == "NEWPW") begin
        if (ec) m_entry.delete();
        else if (ee) begin
          m_entry.push_back(int'(s));
          if (m_entry.size() == N) begin
            for (int i = 0; i < N; i++) m_pw[i] = m_entry[i];
            m_entry.delete();
            m_mode = "LOCKED";
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin m_mode = "LOCKED"; m_fails = 0; end
      end
    end
  endtask

  task automatic step(input logic r, c, e, h, input logic [3:0] s);
    rst = r; bus_if.clr = c; bus_if.ent = e; bus_if.change = h; bus_if.sw = s;
    @(posedge clk);
    model_step(r, c, e, h, s);
    @(negedge clk);
  endtask

  task automatic chk6(input string nm, input int row, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%b exp=%b", nm, row, got, exp);
    end
  endtask

  task automatic chk20(input string nm, input int row, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h exp=%h", nm, row, got, exp);
    end
  endtask

  task automatic add(input logic r, c, e, h, input logic [3:0] s,
                     input bit cl, input logic [5:0] l, input bit cs, input logic [19:0] ss);
    vec_t v;
    v.r = r; v.c = c; v.e = e; v.h = h; v.s = s;
    v.cl = cl; v.led = l; v.cs = cs; v.ssd = ss;
    tbl.push_back(v);
  endtask

  task automatic nop();
    add(0, 0, 0, 0, 4'h0, 0, 6'h0, 0, 20'h0);
  endtask

  task automatic idle_chk(input logic [5:0] l);
    add(0, 0, 0, 0, 4'h0, 1, l, 0, 20'h0);
  endtask

  task automatic press(input int which);
    add(0, which == 0, which == 1, which == 2, 4'h0, 0, 6'h0, 0, 20'h0);
    nop();
  endtask

  task automatic digit(input logic [3:0] d);
    add(0, 0, 1, 0, d, 0, 6'h0, 0, 20'h0);
    add(0, 0, 0, 0, d, 0, 6'h0, 0, 20'h0);
  endtask

  task automatic digits(input logic [15:0] code);
    for (int i = 0; i < N; i++) digit(code[15-4*i -: 4]);
  endtask

  task automatic attempt(input logic [15:0] code);
    press(1);
    digits(code);
    nop();
  endtask

  initial begin
    // Default unlock with blink phase checks during ENTER.
    add(1, 0, 0, 0, 4'h0, 1, LED_LOCK, 1, {CL, BLK, BLK, BLK});
    nop();
    add(0, 0, 1, 0, 4'h0, 1, LED_LOCK, 1, {CL, BLK, BLK, BLK});
    add(0, 0, 0, 0, 4'h0, 1, LED_LOCK, 1, {5'h00, BLK, BLK, BLK});
    add(0, 0, 1, 0, 4'h0, 0, 6'h0, 0, 20'h0);
    add(0, 0, 0, 0, 4'h0, 1, LED_LOCK, 1, {DSH, BLK, BLK, BLK});
    add(0, 0, 1, 0, 4'h0, 0, 6'h0, 0, 20'h0);
    add(0, 0, 0, 0, 4'h0, 1, LED_LOCK, 1, {DSH, DSH, BLK, BLK});
    add(0, 0, 1, 0, 4'h0, 0, 6'h0, 0, 20'h0);
    add(0, 0, 0, 0, 4'h7, 1, LED_LOCK, 1, {DSH, DSH, DSH, 5'h07});
    add(0, 0, 1, 0, 4'h0, 0, 6'h0, 0, 20'h0);
    add(0, 0, 0, 0, 4'h0, 1, LED_LOCK, 1, {DSH, DSH, DSH, DSH});
    add(0, 0, 0, 0, 4'h0, 1, LED_UNL, 1, {5'h00, CP, BLK, BLK});
    // Change password to A53C, wrong then right attempt.
    press(2); idle_chk(LED_UNL);
    digits(16'hA53C); idle_chk(LED_LOCK);
    attempt(16'h0000); idle_chk(6'b001001);
    attempt(16'hA53C); idle_chk(LED_UNL);
    press(1); idle_chk(LED_LOCK);
    // Clear mid-entry counts no failure.
    press(1); digit(4'h1); digit(4'h2); press(0); digits(16'hA53C); nop(); idle_chk(LED_UNL);
    // Clear during NEWPW restarts the staged entry.
    press(2); digit(4'h1); digit(4'h2); press(0); idle_chk(LED_UNL);
    digits(16'h9876); idle_chk(LED_LOCK);
    attempt(16'h9876); idle_chk(LED_UNL);
    // clr and ent together at idx=2: clr wins, no digit written.
    press(1); press(1); digit(4'h9); digit(4'h8);
    add(0, 1, 1, 0, 4'h5, 1, LED_LOCK, 0, 20'h0);
    nop(); digits(16'h9876); nop(); idle_chk(LED_UNL);
    // ent held for 10 cycles is one event.
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 4'h0, 0, 6'h0, 0, 20'h0);
    nop();
    add(0, 0, 0, 0, 4'h0, 1, LED_LOCK, 1, {CL, BLK, BLK, BLK});
    // ent held through reset gives no event.
    add(1, 0, 1, 0, 4'h0, 1, LED_LOCK, 1, {CL, BLK, BLK, BLK});
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 4'h0, 0, 6'h0, 0, 20'h0);
    nop();
    add(0, 0, 0, 0, 4'h0, 1, LED_LOCK, 1, {CL, BLK, BLK, BLK});
    // Three wrong attempts: lockout for 20 cycles, ent ignored.
    attempt(16'h1111); idle_chk(6'b001001);
    attempt(16'h1111); idle_chk(6'b010001);
    attempt(16'h1111);
    for (int m = 2; m <= 20; m++) add(0, 0, m % 2 == 1, 0, 4'h0, 1, 6'b011100, 0, 20'h0);
    idle_chk(LED_LOCK); idle_chk(LED_LOCK);
    attempt(16'h0000); idle_chk(LED_UNL);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].h, tbl[i].s);
      if (tbl[i].cl) chk6("tbl_led", i, bus_if.led, tbl[i].led);
      if (tbl[i].cs) chk20("tbl_ssd", i, bus_if.ssd, tbl[i].ssd);
    end

    // Randomized stimulus against the reference model.
    step(1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 3000; i++) begin
      logic r, c, e, h;
      logic [3:0] s;
      r = ($urandom_range(0, 599) == 0);
      c = ($urandom_range(0, 24) == 0);
      e = ($urandom_range(0, 2) == 0);
      h = ($urandom_range(0, 14) == 0);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      step(r, c, e, h, s);
      chk6("rnd_led", i, bus_if.led, m_led);
      chk20("rnd_ssd", i, bus_if.ssd, m_ssd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
